// File: rtl/ir_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ir_fetch_ctrl
//  Description : Fetch sequencer for a 16-bit instruction register with a
//                byte-wide load port. It clears the IR, then reads two bytes
//                from memory at PC. The first byte goes into IR[7:0] and the
//                second into IR[15:8]. PC advances after each byte.
//  Revision    : 1.0  initial release
// ============================================================================
module ir_fetch_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ir_enable,
  output logic [1:0]        ir_funsel,
  output logic              ir_lh,
  output logic [7:0]        ir_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  // IR function-select encodings
  localparam logic [1:0] C_FUN_CLEAR = 2'b00;
  localparam logic [1:0] C_FUN_LOAD  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RD_LO = 3'd2,
    S_WR_LO = 3'd3,
    S_RD_HI = 3'd4,
    S_WR_HI = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir_data;

  // State register, program counter and captured memory byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir_data <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          // A load in the same cycle as start is honoured, so the fetch
          // that follows uses the freshly loaded PC.
          if (pc_load) r_pc <= pc_load_val;
        end
        S_RD_LO, S_RD_HI: begin
          if (mem_valid) r_ir_data <= mem_data;
        end
        S_WR_LO, S_WR_HI: begin
          // Modulo-2^ADDR_W increment; wrap is silent.
          r_pc <= r_pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    w_next_state = r_state;
    mem_rd       = 1'b0;
    ir_enable    = 1'b0;
    ir_funsel    = C_FUN_CLEAR;
    ir_lh        = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_CLR;
      end
      S_CLR: begin
        ir_enable    = 1'b1;
        ir_funsel    = C_FUN_CLEAR;
        w_next_state = S_RD_LO;
      end
      S_RD_LO: begin
        mem_rd = 1'b1;
        if (mem_valid) w_next_state = S_WR_LO;
      end
      S_WR_LO: begin
        ir_enable    = 1'b1;
        ir_funsel    = C_FUN_LOAD;
        ir_lh        = 1'b0;
        w_next_state = S_RD_HI;
      end
      S_RD_HI: begin
        mem_rd = 1'b1;
        if (mem_valid) w_next_state = S_WR_HI;
      end
      S_WR_HI: begin
        ir_enable    = 1'b1;
        ir_funsel    = C_FUN_LOAD;
        ir_lh        = 1'b1;
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // The memory address always tracks PC; the IR byte holds between captures.
  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign ir_data  = r_ir_data;

endmodule
`default_nettype wire

// File: tb/tb_ir_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ir_fetch_ctrl
//  Description : Directed self-checking bench for ir_fetch_ctrl with a
//                byte memory and a behavioural 16-bit IR model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ir_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [7:0] mem_data;
  logic       mem_valid;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       ir_enable;
  logic [1:0] ir_funsel;
  logic       ir_lh;
  logic [7:0] ir_data;
  logic [7:0] pc;
  logic       busy;
  logic       done;

  logic [7:0]  mem [0:255];
  logic [15:0] ir_model;
  int          n_done = 0;
  int          n_hi   = 0;
  int          total  = 0;
  int          bad    = 0;
  int          exp_done = 0;
  int          exp_hi   = 0;
  logic [7:0]  exp_data;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  ir_fetch_ctrl #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .ir_enable  (ir_enable),
    .ir_funsel  (ir_funsel),
    .ir_lh      (ir_lh),
    .ir_data    (ir_data),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural IR plus strobe counters
  always @(posedge clk) begin
    if (ir_enable) begin
      if (ir_funsel == 2'b00) ir_model <= 16'h0000;
      else if (ir_funsel == 2'b01) begin
        if (ir_lh) ir_model[15:8] <= ir_data;
        else       ir_model[7:0]  <= ir_data;
      end
    end
    if (done) n_done <= n_done + 1;
    if (ir_enable && ir_lh) n_hi <= n_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic rd, input logic [7:0] addr,
                            input logic en, input logic [1:0] fs, input logic lh,
                            input logic [7:0] data, input logic [7:0] p,
                            input logic bz, input logic dn);
    check({tag, ".mem_rd"},    32'(mem_rd),    32'(rd));
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(addr));
    check({tag, ".ir_enable"}, 32'(ir_enable), 32'(en));
    check({tag, ".ir_funsel"}, 32'(ir_funsel), 32'(fs));
    check({tag, ".ir_lh"},     32'(ir_lh),     32'(lh));
    check({tag, ".ir_data"},   32'(ir_data),   32'(data));
    check({tag, ".pc"},        32'(pc),        32'(p));
    check({tag, ".busy"},      32'(busy),      32'(bz));
    check({tag, ".done"},      32'(done),      32'(dn));
  endtask

  task automatic launch(input logic [7:0] p, input bit ld);
    if (ld) begin
      pc_load     = 1'b1;
      pc_load_val = p;
    end
    start = 1'b1;
    tick();
    pc_load = 1'b0;
    start   = 1'b0;
  endtask

  // Called while observing the CLR cycle; walks the rest of the fetch.
  task automatic run_fetch(input logic [7:0] p, input int lo_w, input int hi_w, input bit poke);
    logic [7:0] p1 = p + 8'd1;
    logic [7:0] p2 = p + 8'd2;
    logic [7:0] lo = mem[p];
    logic [7:0] hi = mem[p1];
    expect_out("clr", 0, p, 1, 2'b00, 0, exp_data, p, 1, 0);
    for (int k = 0; k <= lo_w; k++) begin
      tick();
      expect_out("rd_lo", 1, p, 0, 2'b00, 0, exp_data, p, 1, 0);
      mem_valid = (k == lo_w);
    end
    tick();
    expect_out("wr_lo", 0, p, 1, 2'b01, 0, lo, p, 1, 0);
    exp_data = lo;
    for (int k = 0; k <= hi_w; k++) begin
      tick();
      expect_out("rd_hi", 1, p1, 0, 2'b00, 0, lo, p1, 1, 0);
      if (poke && k == 0) begin
        pc_load     = 1'b1;
        pc_load_val = 8'h80;
        start       = 1'b1;
      end
      mem_valid = (k == hi_w);
    end
    tick();
    pc_load = 1'b0;
    start   = 1'b0;
    expect_out("wr_hi", 0, p1, 1, 2'b01, 1, hi, p1, 1, 1);
    tick();
    expect_out("idle", 0, p2, 0, 2'b00, 0, hi, p2, 0, 0);
    exp_data = hi;
    exp_done++;
    exp_hi++;
    check("ir_value", 32'(ir_model), 32'({hi, lo}));
    check("done_count", n_done, exp_done);
    check("hi_strobes", n_hi, exp_hi);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 7 + 3) & 8'hFF);
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    mem[8'hFF] = 8'h11;
    mem[8'h00] = 8'h22;
    rst = 1'b1;
    start = 1'b1;
    pc_load = 1'b0;
    pc_load_val = 8'h00;
    mem_valid = 1'b1;
    exp_data = 8'h00;

    // Reset with start held: outputs stay at zero
    tick();
    tick();
    expect_out("reset", 0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 0, 0);
    check("reset_done_count", n_done, 0);
    rst = 1'b0;
    tick();
    start = 1'b0;
    run_fetch(8'h00, 0, 0, 0);

    // Basic fetch: PC load alone, then a start pulse
    pc_load = 1'b1;
    pc_load_val = 8'h10;
    tick();
    pc_load = 1'b0;
    expect_out("pc_loaded", 0, 8'h10, 0, 2'b00, 0, exp_data, 8'h10, 0, 0);
    launch(8'h10, 0);
    run_fetch(8'h10, 0, 0, 0);
    check("basic_ir", 32'(ir_model), 32'h3CA5);

    // Wait states: 3 in RD_LO, 2 in RD_HI
    launch(8'h30, 1);
    run_fetch(8'h30, 3, 2, 0);

    // Wrap-around from 0xFF
    launch(8'hFF, 1);
    run_fetch(8'hFF, 0, 0, 0);
    check("wrap_ir", 32'(ir_model), 32'h2211);
    check("wrap_pc", 32'(pc), 32'h01);

    // Inputs ignored while busy
    launch(8'h50, 1);
    run_fetch(8'h50, 0, 1, 1);
    tick();
    check("no_retrigger", 32'(busy), 32'h0);
    check("ignored_pc", 32'(pc), 32'h52);

    // Simultaneous load and start in IDLE
    launch(8'h40, 1);
    run_fetch(8'h40, 0, 0, 0);

    // Reset in WR_LO aborts the fetch
    launch(8'h20, 1);
    tick();
    tick();
    expect_out("abort_wr_lo", 0, 8'h20, 1, 2'b01, 0, mem[8'h20], 8'h20, 1, 0);
    rst = 1'b1;
    tick();
    expect_out("abort_reset", 0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 0, 0);
    rst = 1'b0;
    tick();
    expect_out("abort_idle", 0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 0, 0);
    check("abort_done_count", n_done, exp_done);
    check("abort_hi_strobes", n_hi, exp_hi);
    exp_data = 8'h00;
    launch(8'h00, 0);
    run_fetch(8'h00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
